// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_W = 8;

    // Iteration counter width: must be able to hold the value W.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational iteration of the restoring division algorithm.
// The shifted remainder is W+1 bits wide so the carry-in bit from the
// quotient register is never lost before the trial subtraction.
module div_step
    import seq_div_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] q,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] q_next
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // Shift {rem, q} left, trial-subtract, and restore if the result went negative.
    always_comb begin
        shifted = {rem, q[W-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[W]) begin
            rem_next = trial[W-1:0];
            q_next   = {q[W-2:0], 1'b1};
        end else begin
            rem_next = shifted[W-1:0];
            q_next   = {q[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider with start/busy/done handshake.
// One quotient bit is produced per clock; a result appears W+1 cycles
// after the accepting edge. Define SEQ_DIV_ZERO_CHECK_EN to short-cut a
// zero divisor straight to DONE and raise dz; otherwise dz is tied low and
// a zero divisor simply runs the normal iterations (Q = all ones, R = A).
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         dz
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   q_reg;
    logic [W-1:0]   rem_reg;
    logic [W-1:0]   div_reg;
    logic [W-1:0]   q_step;
    logic [W-1:0]   rem_step;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           zero_fast;
    logic           last_iter;
    logic           busy_next;
    logic           done_next;

    div_step #(.W(W)) u_step (
        .rem      (rem_reg),
        .q        (q_reg),
        .divisor  (div_reg),
        .rem_next (rem_step),
        .q_next   (q_step)
    );

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (state == RUN) && (cnt == LAST_ITER);

`ifdef SEQ_DIV_ZERO_CHECK_EN
    assign zero_fast = accept && (B == '0);
`else
    assign zero_fast = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode; DONE accepts a new request just like IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (zero_fast)   state_next = DONE;
                else if (accept) state_next = RUN;
                else             state_next = IDLE;
            end
            RUN: begin
                if (last_iter) state_next = DONE;
                else           state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they come out of flops.
    always_comb begin
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
        end
    end

    // Operand capture on accept, then one division step per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg   <= '0;
            rem_reg <= '0;
            div_reg <= '0;
            cnt     <= '0;
        end else if (accept) begin
            q_reg   <= A;
            rem_reg <= '0;
            div_reg <= B;
            cnt     <= '0;
        end else if (state == RUN) begin
            q_reg   <= q_step;
            rem_reg <= rem_step;
            cnt     <= cnt + CW'(1);
        end
    end

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= '0;
            R <= '0;
        end else if (last_iter) begin
            Q <= q_step;
            R <= rem_step;
        end else if (zero_fast) begin
            Q <= '1;
            R <= A;
        end
    end

`ifdef SEQ_DIV_ZERO_CHECK_EN
    // Divide-by-zero flag tracks the divisor of the most recent result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            dz <= 1'b0;
        else if (last_iter) dz <= 1'b0;
        else if (zero_fast) dz <= 1'b1;
    end
`else
    assign dz = 1'b0;
`endif

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned restoring divider, the inverse of the team's shift-add sequential multiplier. Computes one quotient bit per clock from a W-bit dividend and divisor, with a start/busy/done handshake. Sits beside the multiplier in the arithmetic lab datapath; the multiplier's product is its typical dividend source in round-trip checks.

## Interface
- `W`, default 8, operand and result width. Legal range is 2 to 32.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request pulse; sampled only when not busy
- `A`  in  W  dividend, sampled on the accepting edge
- `B`  in  W  divisor, sampled on the accepting edge
- `busy`  out  1  high while iterating
- `done`  out  1  one-cycle pulse; Q, R and dz are valid
- `Q`  out  W  quotient, registered, held until the next result
- `R`  out  W  remainder, registered, held until the next result
- `dz`  out  1  divide-by-zero flag for the last result

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE with `start`=1:
  - latch A into the quotient shift register, B into the divisor register;
  - clear the partial remainder and the iteration counter;
  - go to RUN.
- RUN, each edge:
  - shift {rem, q} left by 1;
  - form trial = shifted rem − divisor, W+1 bits wide;
  - if trial is non-negative (MSB = 0): rem = trial[W-1:0] and q[0] = 1;
  - otherwise rem keeps the shifted value and q[0] = 0;
  - increment the counter.
- After the W-th iteration, go to DONE and copy q to Q, rem to R.
- DONE lasts one cycle, with `done`=1.
  - `start`=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise return to IDLE.
- `start` is ignored in RUN. The operand registers never change mid-operation.
- All arithmetic is unsigned. The partial remainder uses W+1 bits internally so the shifted value cannot overflow.

## Timing
- Reset values: state=IDLE, and busy, done, dz, Q and R are all 0. The internal registers are also 0.
- Latency: accept at edge k. Iterations run on edges k+1 … k+W. `done` is high in the cycle after edge k+W.
- Throughput: one division every W+1 cycles, back-to-back.
- `busy` = (state==RUN). It is a registered decode and is never high together with `done`.
- Q, R and dz update only on the edge that enters DONE. They hold through IDLE and RUN.
- Reset asserted mid-RUN or in DONE: outputs clear immediately (asynchronous), with no `done` pulse. After `rst` deasserts, the block waits in IDLE for a fresh `start`.
- `start` in the same cycle that `rst` deasserts is accepted on the first clean edge.

## Configuration
- `SEQ_DIV_ZERO_CHECK_EN` defined:
  - B==0 at accept goes straight to DONE on the next edge, skipping RUN;
  - results are Q = all ones, R = A, dz = 1;
  - dz is 0 for every nonzero divisor.
- Not defined:
  - B==0 runs the normal W iterations;
  - the algorithm naturally yields Q = all ones and R = A;
  - `dz` is tied to 0.

## Structure
- Package `seq_div_pkg`:
  - state enum (IDLE, RUN, DONE);
  - default width constant;
  - counter width, $clog2(W+1).
- Sub-module `div_step` is natural. It is a purely combinational single iteration: (rem, q, divisor) → (rem_next, q_next). It is unit-testable on its own.
- The top level holds the FSM, counter, operand registers and output registers.

## Test plan
- Reset, then A=200, B=7, `start` pulse:
  - `busy` high for 8 cycles, then `done` one cycle;
  - Q=28, R=4, dz=0.
- A=255, B=1 → Q=255, R=0. Then A=5, B=9 → Q=0, R=5.
- A=100, B=0:
  - with the macro, `done` 1 cycle after accept, Q=0xFF, R=100, dz=1;
  - without it, `done` after 8 iterations, Q=0xFF, R=100, dz=0.
- Re-assert `start` with new operands during RUN → ignored. `start` held during DONE → second division accepted with no idle gap.
- Assert `rst` at iteration 4 → busy, done, Q and R go to 0 immediately. After release, A=50, B=5 gives Q=10, R=0.
- 10k random W=8 pairs (B≠0), including multiplier products truncated to 8 bits → Q*B+R==A and R<B for every result.
